// File: rtl/movegen_sequencer_if.sv
// Board-feed and move-stream handshakes of the move-generator sequencer.
// The slave side is the sequencer; the master side is feeder plus consumer.
interface movegen_sequencer_if;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_data;
   logic       mv_valid;
   logic       mv_ready;
   logic [5:0] mv_from;
   logic [5:0] mv_to;

   modport master (
      output in_valid, in_data, mv_ready,
      input  in_ready, mv_valid, mv_from, mv_to
   );

   modport slave (
      input  in_valid, in_data, mv_ready,
      output in_ready, mv_valid, mv_from, mv_to
   );
endinterface

// File: rtl/movegen_sequencer.sv
// Move-generator array controller: loads the square chain, then walks
// side-to-move squares and streams (from, to) moves one per handshake.
module movegen_sequencer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             i_wtp,
   input  logic [3:0]       i_castle_rights,
   movegen_sequencer_if.slave bus,
   output logic             o_pos_valid,
   output logic [3:0]       o_pos_data,
   output logic             o_wtp,
   output logic [3:0]       o_castle_rights,
   output logic [63:0]      o_emit_move,
   input  logic [63:0]      i_target,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] move_count
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SELECT,
      S_SETTLE,
      S_EMIT,
      S_DONE
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic             wtp_q, wtp_d;
   logic [3:0]       castle_q, castle_d;
   logic [5:0]       ld_q, ld_d;
   logic [63:0]      player_q, player_d;
   logic [5:0]       src_q, src_d;
   logic [63:0]      emit_q, emit_d;
   logic [63:0]      tgt_q, tgt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic       beat;
   logic       mv_fire;
   logic       own;
   logic [5:0] low_idx;

   // Lowest set bit wins: scan high to low, last hit overrides.
   always_comb begin
      low_idx = '0;
      for (int i = 63; i >= 0; i--) begin
         if (tgt_q[i]) low_idx = 6'(i);
      end
   end

   assign bus.in_ready = (state_q == S_LOAD);
   assign beat         = bus.in_valid & bus.in_ready;
   assign bus.mv_valid = (state_q == S_EMIT) && (tgt_q != '0);
   assign bus.mv_from  = src_q;
   assign bus.mv_to    = low_idx;
   assign mv_fire      = bus.mv_valid & bus.mv_ready;

   assign own = (bus.in_data[2:0] != 3'd0) &&
                (bus.in_data[3] == wtp_q);

   assign o_pos_valid     = beat;
   assign o_pos_data      = bus.in_data;
   assign o_wtp           = wtp_q;
   assign o_castle_rights = castle_q;
   assign o_emit_move     = emit_q;
   assign busy            = (state_q != S_IDLE);
   assign done            = (state_q == S_DONE);
   assign move_count      = cnt_q;

   always_comb begin
      state_d  = state_q;
      wtp_d    = wtp_q;
      castle_d = castle_q;
      ld_d     = ld_q;
      player_d = player_q;
      src_d    = src_q;
      emit_d   = emit_q;
      tgt_d    = tgt_q;
      cnt_d    = cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               wtp_d    = i_wtp;
               castle_d = i_castle_rights;
               cnt_d    = '0;
               ld_d     = '0;
               player_d = '0;
               state_d  = S_LOAD;
            end
         end
         S_LOAD: begin
            if (beat) begin
               // Beats arrive square 63 first, so the index is 63-ld.
               player_d[~ld_q] = own;
               ld_d            = ld_q + 6'd1;
               if (ld_q == 6'd63) begin
                  src_d   = '0;
                  state_d = S_SELECT;
               end
            end
         end
         S_SELECT: begin
            if (player_q[src_q]) begin
               emit_d  = 64'd1 << src_q;
               state_d = S_SETTLE;
            end else if (src_q == 6'd63) begin
               state_d = S_DONE;
            end else begin
               src_d = src_q + 6'd1;
            end
         end
         S_SETTLE: begin
            tgt_d   = i_target;
            emit_d  = '0;
            state_d = S_EMIT;
         end
         S_EMIT: begin
            if (tgt_q == '0) begin
               if (src_q == 6'd63) begin
                  state_d = S_DONE;
               end else begin
                  src_d   = src_q + 6'd1;
                  state_d = S_SELECT;
               end
            end else if (mv_fire) begin
               tgt_d = tgt_q & (tgt_q - 64'd1);
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         wtp_q    <= 1'b0;
         castle_q <= '0;
         ld_q     <= '0;
         player_q <= '0;
         src_q    <= '0;
         emit_q   <= '0;
         tgt_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         wtp_q    <= wtp_d;
         castle_q <= castle_d;
         ld_q     <= ld_d;
         player_q <= player_d;
         src_q    <= src_d;
         emit_q   <= emit_d;
         tgt_q    <= tgt_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule
